// File: rtl/cache_pkg.sv
// Shared cache geometry and line-mover state encoding.
package cache_pkg;

  localparam int unsigned ADDR_W         = 12;
  localparam int unsigned BLK_W          = 8;
  localparam int unsigned OFF_W          = 4;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned NUM_SETS       = 8;
  localparam int unsigned NUM_WAYS       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } mover_state_e;

endpackage

// File: rtl/cache_line_mover.sv
// Line-transfer engine: optional dirty-victim write-back followed by a line
// fill, each serialized into 16 single-word memory handshakes.
// Build option: CACHE_LINE_MOVER_CRIT_WORD_FIRST_EN starts the fill at the
// missed word offset and wraps modulo 16; otherwise the fill starts at 0.
module cache_line_mover
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BLK_W-1:0]  req_fill_blk,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic              req_wb_en,
  input  logic [BLK_W-1:0]  req_wb_blk,
  output logic [OFF_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_word,
  output logic              fill_valid,
  output logic [OFF_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [OFF_W-1:0] OFF_ONE = OFF_W'(1);

  mover_state_e      state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [OFF_W-1:0]  start_q, start_d;
  logic [BLK_W-1:0]  fill_blk_q, fill_blk_d;
  logic [BLK_W-1:0]  wb_blk_q, wb_blk_d;
  logic              fill_valid_q, fill_valid_d;
  logic [OFF_W-1:0]  fill_idx_q, fill_idx_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              done_q, done_d;

  logic [OFF_W-1:0]  req_start;
  logic [OFF_W-1:0]  cnt_inc;

`ifdef CACHE_LINE_MOVER_CRIT_WORD_FIRST_EN
  assign req_start = req_offset;
`else
  logic unused_req_offset;
  assign req_start         = '0;
  assign unused_req_offset = ^req_offset;
`endif

  assign cnt_inc = cnt_q + OFF_ONE;

  // Next-state, counter and combinational memory/cache-side outputs.
  // The fill ends when the incremented counter comes back round to the start
  // index, which covers both the 0..15 order and the wrapped order.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    fill_blk_d   = fill_blk_q;
    wb_blk_d     = wb_blk_q;
    fill_valid_d = 1'b0;
    fill_idx_d   = fill_idx_q;
    fill_data_d  = fill_data_q;
    done_d       = 1'b0;
    req_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    wb_idx       = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          fill_blk_d = req_fill_blk;
          wb_blk_d   = req_wb_blk;
          start_d    = req_start;
          if (req_wb_en) begin
            state_d = WB;
            cnt_d   = '0;
          end else begin
            state_d = FILL;
            cnt_d   = req_start;
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_blk_q, cnt_q};
        wb_idx    = cnt_q;
        mem_wdata = wb_word;
        if (mem_ack) begin
          cnt_d = cnt_inc;
          if (cnt_q == '1) begin
            state_d = FILL;
            cnt_d   = start_q;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {fill_blk_q, cnt_q};
        if (mem_ack) begin
          fill_valid_d = 1'b1;
          fill_idx_d   = cnt_q;
          fill_data_d  = mem_rdata;
          cnt_d        = cnt_inc;
          if (cnt_inc == start_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, latched request and registered fill/done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= '0;
      fill_blk_q   <= '0;
      wb_blk_q     <= '0;
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      fill_blk_q   <= fill_blk_d;
      wb_blk_q     <= wb_blk_d;
      fill_valid_q <= fill_valid_d;
      fill_idx_q   <= fill_idx_d;
      fill_data_q  <= fill_data_d;
      done_q       <= done_d;
    end
  end

  assign fill_valid = fill_valid_q;
  assign fill_idx   = fill_idx_q;
  assign fill_data  = fill_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cache_line_mover.sv
// Self-checking bench for cache_line_mover: transaction-level reference of
// the memory-operation sequence and fill beats, with a randomly stalling
// memory. Honours CACHE_LINE_MOVER_CRIT_WORD_FIRST_EN for the fill order.
`timescale 1ns/1ps
module tb_cache_line_mover;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [BLK_W-1:0]  req_fill_blk;
  logic [OFF_W-1:0]  req_offset;
  logic              req_wb_en;
  logic [BLK_W-1:0]  req_wb_blk;
  logic [OFF_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_word;
  logic              fill_valid;
  logic [OFF_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  always #5 clk = ~clk;

  cache_line_mover dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_fill_blk (req_fill_blk),
    .req_offset   (req_offset),
    .req_wb_en    (req_wb_en),
    .req_wb_blk   (req_wb_blk),
    .wb_idx       (wb_idx),
    .wb_word      (wb_word),
    .fill_valid   (fill_valid),
    .fill_idx     (fill_idx),
    .fill_data    (fill_data),
    .done         (done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  // Memory as seen by the DUT, and the reference's view of memory contents.
  logic [DATA_W-1:0] mem     [0:4095];
  logic [DATA_W-1:0] ref_mem [0:4095];
  logic [DATA_W-1:0] victim  [0:15];

  assign wb_word   = victim[wb_idx];
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OFF_W-1:0] fill_start(input logic [OFF_W-1:0] off);
`ifdef CACHE_LINE_MOVER_CRIT_WORD_FIRST_EN
    return off;
`else
    return '0;
`endif
  endfunction

  // Runs one request. stall_pct: chance (%) of a wait cycle per word.
  // lat_exp: expected done cycle after accept (0 = not checked).
  // rst_at: assert reset on this fill ack number (0 = never).
  task automatic run_txn(input logic [BLK_W-1:0] fblk, input logic wb_en,
                         input logic [BLK_W-1:0] wblk, input logic [OFF_W-1:0] off,
                         input int unsigned stall_pct, input int unsigned lat_exp,
                         input int unsigned rst_at);
    op_t               ops[$];
    op_t               o;
    logic [OFF_W-1:0]  idx;
    logic              ack;
    bit                beat_pend = 1'b0;
    bit                done_exp  = 1'b0;
    logic [OFF_W-1:0]  pend_idx  = '0;
    logic [DATA_W-1:0] pend_data = '0;
    int unsigned       fill_acks = 0;
    int unsigned       t         = 1;

    if (wb_en) begin
      for (int k = 0; k < 16; k++) begin
        idx    = OFF_W'(k);
        o.we   = 1'b1;
        o.addr = {wblk, idx};
        o.data = victim[k];
        ops.push_back(o);
        ref_mem[o.addr] = victim[k];
      end
    end
    for (int i = 0; i < 16; i++) begin
      idx    = fill_start(off) + OFF_W'(i);
      o.we   = 1'b0;
      o.addr = {fblk, idx};
      o.data = ref_mem[o.addr];
      ops.push_back(o);
    end

    check("ready_before_req", req_ready, 1);
    req_valid    = 1'b1;
    req_fill_blk = fblk;
    req_wb_en    = wb_en;
    req_wb_blk   = wblk;
    req_offset   = off;
    mem_ack      = 1'b0;
    @(posedge clk); #1;

    forever begin
      if (t > 600) begin
        check("timeout", t, 0);
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        return;
      end
      // Fields change while busy; the held request must be ignored.
      req_fill_blk = BLK_W'($urandom);
      req_wb_blk   = BLK_W'($urandom);
      req_wb_en    = 1'($urandom);
      req_offset   = OFF_W'($urandom);

      check("ready_busy", req_ready, 0);
      check("fill_valid", fill_valid, beat_pend);
      if (beat_pend && fill_valid) begin
        check("fill_idx", fill_idx, pend_idx);
        check("fill_data", fill_data, pend_data);
      end
      check("done", done, done_exp);

      if (done_exp) begin
        check("mem_req_done", mem_req, 0);
        if (lat_exp != 0) check("done_latency", t, lat_exp);
        req_valid = 1'b0;
        mem_ack   = 1'($urandom);
        @(posedge clk); #1;
        check("ready_after", req_ready, 1);
        check("fill_valid_after", fill_valid, 0);
        check("done_after", done, 0);
        mem_ack = 1'b0;
        return;
      end

      check("mem_req", mem_req, ops.size() > 0);
      if (mem_req && ops.size() > 0) begin
        check("mem_addr", mem_addr, ops[0].addr);
        check("mem_we", mem_we, ops[0].we);
        if (ops[0].we) check("mem_wdata", mem_wdata, ops[0].data);
      end

      ack       = ($urandom_range(99) >= stall_pct);
      beat_pend = 1'b0;
      if (ack && mem_req && ops.size() > 0) begin
        o = ops.pop_front();
        if (o.we) begin
          mem[o.addr] = mem_wdata;
        end else begin
          beat_pend = 1'b1;
          pend_idx  = o.addr[OFF_W-1:0];
          pend_data = o.data;
          fill_acks++;
        end
        if (ops.size() == 0) done_exp = 1'b1;
      end
      mem_ack = ack;

      if (rst_at != 0 && beat_pend && fill_acks == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_ready", req_ready, 1);
        check("rst_fill_valid", fill_valid, 0);
        check("rst_done", done, 0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
          mem_ack = 1'($urandom);
          @(posedge clk); #1;
          check("post_rst_fill_valid", fill_valid, 0);
          check("post_rst_done", done, 0);
          check("post_rst_mem_req", mem_req, 0);
        end
        mem_ack = 1'b0;
        return;
      end

      @(posedge clk); #1;
      t++;
    end
  endtask

  initial begin
    logic [11:0] a;
    logic [BLK_W-1:0] fb, wbk;

    for (int i = 0; i < 4096; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int k = 0; k < 16; k++) begin
      a          = {8'h22, 4'(k)};
      mem[a]     = 32'(k + 100);
      ref_mem[a] = 32'(k + 100);
      victim[k]  = 32'(k * 3);
    end

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_fill_blk = '0;
    req_offset   = '0;
    req_wb_en    = 1'b0;
    req_wb_blk   = '0;
    mem_ack      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("reset_ready", req_ready, 1);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_fill_valid", fill_valid, 0);
    check("reset_fill_idx", fill_idx, 0);
    check("reset_fill_data", fill_data, 0);
    check("reset_done", done, 0);
    check("reset_wb_idx", wb_idx, 0);

    // Spurious acks while idle.
    for (int c = 0; c < 4; c++) begin
      mem_ack = 1'b1;
      @(posedge clk); #1;
      check("idle_mem_req", mem_req, 0);
      check("idle_ready", req_ready, 1);
      check("idle_fill_valid", fill_valid, 0);
    end
    mem_ack = 1'b0;

    // Clean fill, zero wait.
    run_txn(8'h22, 1'b0, 8'h00, 4'd0, 0, 17, 0);
    // Dirty victim write-back then fill.
    run_txn(8'h93, 1'b1, 8'h13, 4'd0, 0, 33, 0);
    // Critical-word offset 13 (ordering depends on build).
    run_txn(8'h22, 1'b0, 8'h00, 4'd13, 0, 17, 0);
    // Write-back of the same block being filled returns the written data.
    for (int k = 0; k < 16; k++) victim[k] = $urandom;
    run_txn(8'h5A, 1'b1, 8'h5A, 4'd7, 0, 33, 0);
    // 50% stalls with write-back.
    for (int k = 0; k < 16; k++) victim[k] = $urandom;
    run_txn(8'hC4, 1'b1, 8'h31, 4'd2, 50, 0, 0);
    // Reset at the 5th fill ack.
    run_txn(8'h22, 1'b0, 8'h00, 4'd0, 0, 0, 5);
    run_txn(8'h22, 1'b0, 8'h00, 4'd9, 30, 0, 0);

    // Random traffic.
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 16; k++) victim[k] = $urandom;
      fb  = BLK_W'($urandom);
      wbk = ($urandom_range(3) == 0) ? fb : BLK_W'($urandom);
      run_txn(fb, 1'($urandom), wbk, OFF_W'($urandom), $urandom_range(60), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_line_mover.md
# cache_line_mover

Line-transfer engine between the 4-way, 8-set, 16-word-line write-back cache and main memory (256 blocks × 16 words, 12-bit word address). On a cache miss it accepts one request: an optional dirty-victim write-back followed by a line fill. Each is serialized into 16 single-word memory handshakes. Fill words stream back to the cache data array, and completion is signalled with a one-cycle pulse.

## Interface
- ADDR_W, 12, word address width = BLK_W + OFF_W
- BLK_W, 8, memory block number width (tag[4:0] ++ set[2:0])
- OFF_W, 4, word offset width; 2**OFF_W = 16 words per line
- DATA_W, 32, word width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  cache presents a miss request
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready
- req_fill_blk  in  BLK_W  block to fetch
- req_offset  in  OFF_W  missed word offset (used only with critical-word-first)
- req_wb_en  in  1  victim is dirty and must be written back first
- req_wb_blk  in  BLK_W  victim block number (tag ++ set)
- wb_idx  out  OFF_W  word index the cache must drive on wb_word this cycle
- wb_word  in  DATA_W  victim word at wb_idx (combinational read of cache array)
- fill_valid  out  1  fill word valid (registered)
- fill_idx  out  OFF_W  word offset of fill_data
- fill_data  out  DATA_W  fill word
- done  out  1  one-cycle pulse: request complete
- mem_req  out  1  memory access request, held until acked
- mem_we  out  1  1 = write (write-back), 0 = read (fill)
- mem_addr  out  ADDR_W  {block, word index}
- mem_wdata  out  DATA_W  equals wb_word during WB
- mem_rdata  in  DATA_W  read data, valid when mem_ack is high in FILL
- mem_ack  in  1  access completes in the cycle it is sampled high with mem_req

## Operation
- States: IDLE → (req_wb_en ? WB : FILL) on accept; WB → FILL after the 16th ack; FILL → DONE after the 16th ack; DONE → IDLE unconditionally.
- Accept: latch fill_blk, wb_blk, offset and wb_en; clear the 4-bit word counter. In FILL, the counter is preset to the start index.
- WB: mem_req=1, mem_we=1, mem_addr={wb_blk, cnt}, wb_idx=cnt, mem_wdata=wb_word. On ack, cnt increments; the 16th ack leaves WB.
- FILL: mem_req=1, mem_we=0, mem_addr={fill_blk, cnt}. On ack, next cycle fill_valid=1, fill_idx=cnt, fill_data=mem_rdata.
- Write-back always precedes fill, so a fill of the same block returns the just-written data.
- The counter is modulo 16; wrap-around from 15 to 0 is legal and expected with critical-word-first.
- mem_ack while mem_req=0 is ignored. req_valid while busy is ignored (req_ready=0); the request is not queued.
- Reset (rst_n=0 at an edge), including mid-transfer: state IDLE, counters 0. The in-flight transfer is abandoned, and no done or fill_valid is produced afterward.
- Reset values: req_ready=1 after reset release; mem_req=0, mem_we=0, mem_addr=0, fill_valid=0, fill_idx=0, fill_data=0, done=0, wb_idx=0.
- mem_addr, mem_we, mem_req and wb_idx are combinational from state and counter. fill_* and done are registered.

## Timing
- Accept at edge T0. mem_req is first high in cycle T1.
- Back-to-back: if mem_ack is high in the same cycle, the next word's address appears in the next cycle with mem_req still high. No idle cycle occurs between words or between WB and FILL.
- Zero-wait memory, no WB: fill acks at T1..T16, fill_valid at T2..T17, done coincident with the last fill_valid at T17, req_ready high at T18.
- With WB: add 16 cycles, giving done at T33 and req_ready at T34.
- Each memory wait cycle (mem_ack=0) adds exactly one cycle. mem_addr, mem_we and mem_wdata are stable while waiting.

## Configuration
- CACHE_LINE_MOVER_CRIT_WORD_FIRST_EN defined: FILL starts at cnt=req_offset and wraps modulo 16, ending at req_offset−1. fill_idx reports the true offset. WB order is unchanged (0..15).
- Not defined: FILL always starts at 0 and req_offset is ignored. Latency is the same in both builds.

## Structure
- Shared package cache_pkg: ADDR_W, BLK_W, OFF_W, DATA_W, WORDS_PER_LINE=16, NUM_SETS=8, NUM_WAYS=4, and the mover_state_e enum (IDLE, WB, FILL, DONE).
- Single module. No sub-module is warranted; the counter and FSM are inline.

## Test plan
- Clean fill, blk 0x22, ack every cycle, Memory[0x22][k]=k+100 → 16 fill_valid beats with idx 0..15 and data 100..115, done at T17, no mem_we.
- Dirty victim wb_blk 0x13 and fill_blk 0x93, wb_word=idx*3 → writes at mem_addr 0x130..0x13F with data 0,3,…,45, then reads 0x930..0x93F, done at T33.
- Random mem_ack stalls (50%) → address and wdata held stable during stalls, exactly 32 acks consumed, done once.
- req_valid asserted throughout a transfer → no second accept until T18/T34; spurious mem_ack in IDLE has no effect.
- rst_n=0 at the 5th fill ack → next cycle mem_req=0 and req_ready=1, no done, no further fill_valid.
- CRIT_WORD_FIRST_EN with req_offset=13 → fill_idx sequence 13,14,15,0,…,12 at mem_addr {blk,13}…{blk,12}.
